// File: rtl/fp_mult_round_pack_if.sv
// Handshake and data bundle between the FP multiplier execute stage,
// the round/pack stage and the downstream consumer.
// The slave modport is the round/pack stage; the master modport is its environment.
interface fp_mult_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        Sp;
  logic [8:0]  NormE;
  logic [22:0] NormM;
  logic        GRS;
  logic        exc_nan;
  logic        exc_inf;
  logic        exc_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] P;
  logic [3:0]  flags;
  logic        flags_clr;

  modport master (
    output in_valid, Sp, NormE, NormM, GRS, exc_nan, exc_inf, exc_zero,
    output out_ready, flags_clr,
    input  in_ready, out_valid, P, flags
  );

  modport slave (
    input  in_valid, Sp, NormE, NormM, GRS, exc_nan, exc_inf, exc_zero,
    input  out_ready, flags_clr,
    output in_ready, out_valid, P, flags
  );
endinterface

// File: rtl/fp_mult_round_pack.sv
// fp_mult_round_pack: final stage of the FP multiplier.
// Stage 1 applies the round increment and removes the doubled bias,
// stage 2 classifies exceptions / overflow / underflow and packs an
// IEEE-754 single-precision result. Two-entry valid/ready pipeline.
// Optional: define FPM_STICKY_FLAGS_EN to make flags a sticky register
// accumulated on each output transfer and cleared by flags_clr.
// flags = {invalid, overflow, underflow, inexact}.
module fp_mult_round_pack #(
  parameter int BIAS    = 127,
  parameter int EXP_MAX = 255
) (
  input logic                 clk,
  input logic                 rst,
  fp_mult_round_pack_if.slave bus
);

  localparam logic signed [10:0] EXP_MAX_S = 11'(EXP_MAX);
  localparam logic [31:0]        QNAN      = 32'h7FC0_0000;

  // Pipeline valid bits: vldPipe[1] = stage 1, vldPipe[2] = stage 2.
  logic [2:1] vldPipe;
  logic       s2Advance;
  logic       inReady;
  logic       loadS1;
  logic       loadS2;

  // Stage 1 registered fields.
  logic               s1Sp;
  logic signed [10:0] s1Eu;
  logic [22:0]        s1M;
  logic               s1Grs;
  logic               s1Lost;
  logic               s1Nan;
  logic               s1Inf;
  logic               s1Zero;

  // Stage 1 combinational round/adjust.
  logic [23:0]        mr;
  logic signed [10:0] eu;

  // Stage 2 combinational classify/pack and registers.
  logic [31:0] nextP;
  logic [3:0]  nextFlags;
  logic [31:0] pReg;
  logic [3:0]  s2Flags;
  logic [3:0]  flagsOut;

  assign s2Advance = !vldPipe[2] | bus.out_ready;
  assign inReady   = !vldPipe[1] | s2Advance;
  assign loadS1    = bus.in_valid & inReady;
  assign loadS2    = vldPipe[1] & s2Advance;

  // Carry out of the mantissa leaves mr[22:0] all zero, which is exactly
  // the renormalised mantissa, so no explicit mux is needed.
  assign mr = {1'b0, bus.NormM} + {23'd0, bus.GRS};
  // 11 bits hold the full range -127..385 without truncation.
  assign eu = {2'b00, bus.NormE} - 11'(BIAS) + {10'd0, mr[23]};

  // Valid bits: stage 1 refills whenever it can accept, stage 2 when it can advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vldPipe <= '0;
    end else begin
      if (inReady)   vldPipe[1] <= bus.in_valid;
      if (s2Advance) vldPipe[2] <= vldPipe[1];
    end
  end

  // Stage 1 data capture on an input transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1Sp   <= 1'b0;
      s1Eu   <= '0;
      s1M    <= '0;
      s1Grs  <= 1'b0;
      s1Lost <= 1'b0;
      s1Nan  <= 1'b0;
      s1Inf  <= 1'b0;
      s1Zero <= 1'b0;
    end else if (loadS1) begin
      s1Sp   <= bus.Sp;
      s1Eu   <= eu;
      s1M    <= mr[22:0];
      s1Grs  <= bus.GRS;
      s1Lost <= (bus.NormM != 23'd0) | bus.GRS;
      s1Nan  <= bus.exc_nan;
      s1Inf  <= bus.exc_inf;
      s1Zero <= bus.exc_zero;
    end
  end

  // Classify in priority order and build the packed word plus its flags.
  always_comb begin
    nextP     = {s1Sp, s1Eu[7:0], s1M};
    nextFlags = {3'b000, s1Grs};
    if (s1Nan | (s1Inf & s1Zero)) begin
      nextP     = QNAN;
      nextFlags = 4'b1000;
    end else if (s1Inf) begin
      nextP     = {s1Sp, 8'hFF, 23'h0};
      nextFlags = 4'b0000;
    end else if (s1Zero) begin
      nextP     = {s1Sp, 31'h0};
      nextFlags = 4'b0000;
    end else if (s1Eu >= EXP_MAX_S) begin
      nextP     = {s1Sp, 8'hFF, 23'h0};
      nextFlags = 4'b0101;
    end else if (s1Eu <= 11'sd0) begin
      // Flush to zero; no subnormal output.
      nextP     = {s1Sp, 31'h0};
      nextFlags = {3'b001, s1Lost};
    end
  end

  // Stage 2 holds while stalled, so P and flags stay stable until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pReg    <= '0;
      s2Flags <= '0;
    end else if (loadS2) begin
      pReg    <= nextP;
      s2Flags <= nextFlags;
    end
  end

`ifdef FPM_STICKY_FLAGS_EN
  // Sticky flags: clear wins over accumulating the result being handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flagsOut <= '0;
    end else if (bus.flags_clr) begin
      flagsOut <= '0;
    end else if (vldPipe[2] & bus.out_ready) begin
      flagsOut <= flagsOut | s2Flags;
    end
  end
`else
  // Per-result flags, meaningful only alongside out_valid.
  logic unusedFlagsClr;
  assign unusedFlagsClr = bus.flags_clr;
  assign flagsOut       = s2Flags;
`endif

  assign bus.in_ready  = inReady;
  assign bus.out_valid = vldPipe[2];
  assign bus.P         = pReg;
  assign bus.flags     = flagsOut;

endmodule

// File: tb/tb_fp_mult_round_pack.sv
// Bench for fp_mult_round_pack: scoreboard of expected {P, flags} pushed on
// each input transfer and popped by a monitor on each output transfer.
module tb_fp_mult_round_pack;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_mult_round_pack_if bus();
  fp_mult_round_pack dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  f;
  } res_t;

  res_t       sbq[$];
  res_t       monExp;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] accum  = 4'h0;
  int         dummyWaits;

  // Reference model: spec-level arithmetic on plain integers.
  function automatic res_t model(input logic sp, input logic [8:0] e, input logic [22:0] m,
                                 input logic g, input logic nan, input logic inf, input logic zero);
    res_t r;
    int mr, carry, eu;
    logic [7:0] eb;
    mr = int'(m) + int'(g);
    carry = (mr >= 32'h0080_0000) ? 1 : 0;
    if (carry == 1) mr = 0;
    eu = int'(e) - 127 + carry;
    eb = 8'(eu);
    if (nan || (inf && zero)) begin r.p = 32'h7FC0_0000; r.f = 4'b1000; end
    else if (inf)             begin r.p = {sp, 8'hFF, 23'h0}; r.f = 4'b0000; end
    else if (zero)            begin r.p = {sp, 31'h0}; r.f = 4'b0000; end
    else if (eu >= 255)       begin r.p = {sp, 8'hFF, 23'h0}; r.f = 4'b0101; end
    else if (eu <= 0)         begin r.p = {sp, 31'h0}; r.f = {3'b001, (m != 23'd0) || g}; end
    else                      begin r.p = {sp, eb, 23'(mr)}; r.f = {3'b000, g}; end
    return r;
  endfunction

  // Output monitor: compare each accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: got P=%h with nothing expected", bus.P);
      end else begin
        monExp = sbq.pop_front();
        if (bus.P !== monExp.p) begin
          errors++;
          $display("FAIL result_P: got %h expected %h", bus.P, monExp.p);
        end
        checks++;
`ifdef FPM_STICKY_FLAGS_EN
        if (bus.flags !== accum) begin
          errors++;
          $display("FAIL sticky_flags: got %b expected %b", bus.flags, accum);
        end
        accum = accum | monExp.f;
`else
        if (bus.flags !== monExp.f) begin
          errors++;
          $display("FAIL result_flags: got %b expected %b (P=%h)", bus.flags, monExp.f, monExp.p);
        end
`endif
      end
    end
  end

  // Present one input and wait (bounded) for its transfer; returns at posedge+1.
  task automatic send(input logic sp, input logic [8:0] e, input logic [22:0] m, input logic g,
                      input logic nan, input logic inf, input logic zero, output int waits);
    bus.Sp = sp; bus.NormE = e; bus.NormM = m; bus.GRS = g;
    bus.exc_nan = nan; bus.exc_inf = inf; bus.exc_zero = zero;
    bus.in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        sbq.push_back(model(sp, e, m, g, nan, inf, zero));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waits++;
      if (waits > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, waits);
        break;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.Sp = 0; bus.NormE = 0; bus.NormM = 0; bus.GRS = 0;
    bus.exc_nan = 0; bus.exc_inf = 0; bus.exc_zero = 0; bus.out_ready = 1; bus.flags_clr = 0;
    rst = 1'b0;
    #2;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.P !== 32'h0) begin errors++; $display("FAIL reset_P: got %h expected 0", bus.P); end
    if (bus.flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b expected 0", bus.flags); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_normal();
    bus.out_ready = 1;
    send(0, 9'd255, 23'h400000, 0, 0, 0, 0, dummyWaits);  // 1.5 x 2.0
    idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid=%b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL latency_2: out_valid=%b expected 1", bus.out_valid); end
    @(posedge clk); #1;
    send(0, 9'd254, 23'h7FFFFF, 1, 0, 0, 0, dummyWaits);  // rounding carry
    send(0, 9'd381, 23'h7FFFFE, 0, 0, 0, 0, dummyWaits);  // largest finite exponent
    send(1, 9'd128, 23'h000001, 1, 0, 0, 0, dummyWaits);  // smallest normal exponent
    send(0, 9'd127, 23'h000000, 0, 0, 0, 0, dummyWaits);  // Eu=0, exact underflow
    drain();
  endtask

  task automatic test_overflow_underflow();
    send(1, 9'd400, 23'h000000, 0, 0, 0, 0, dummyWaits);
    send(1, 9'd100, 23'h123456, 0, 0, 0, 0, dummyWaits);
    send(0, 9'd511, 23'h7FFFFF, 1, 0, 0, 0, dummyWaits);  // Eu=385
    send(0, 9'd0,   23'h000000, 0, 0, 0, 0, dummyWaits);  // Eu=-127
    send(0, 9'd382, 23'h000000, 0, 0, 0, 0, dummyWaits);  // Eu=255
    send(1, 9'd381, 23'h7FFFFF, 1, 0, 0, 0, dummyWaits);  // carry into Eu=255
    drain();
  endtask

  task automatic test_exceptions();
    send(0, 9'd255, 23'h0,      0, 1, 0, 0, dummyWaits);  // NaN operand
    send(0, 9'd255, 23'h0,      0, 0, 1, 1, dummyWaits);  // inf x zero
    send(1, 9'd0,   23'h1,      1, 0, 1, 0, dummyWaits);  // inf beats underflow
    send(1, 9'd255, 23'h0,      0, 0, 0, 1, dummyWaits);  // zero
    send(0, 9'd500, 23'h7FFFFF, 1, 0, 0, 1, dummyWaits);  // zero beats overflow
    send(1, 9'd500, 23'h0,      0, 1, 1, 0, dummyWaits);  // NaN beats inf
    drain();
  endtask

  task automatic test_backpressure();
    res_t expA;
    expA = model(0, 9'd200, 23'h0ABCDE, 0, 0, 0, 0);
    bus.out_ready = 0;
    send(0, 9'd200, 23'h0ABCDE, 0, 0, 0, 0, dummyWaits);
    send(1, 9'd201, 23'h111111, 1, 0, 0, 0, dummyWaits);
    bus.Sp = 0; bus.NormE = 9'd202; bus.NormM = 23'h222222; bus.GRS = 0; bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
      if (bus.P !== expA.p) begin errors++; $display("FAIL bp_hold_P: got %h expected %h", bus.P, expA.p); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1;
    send(0, 9'd202, 23'h222222, 0, 0, 0, 0, dummyWaits);
    send(1, 9'd60,  23'h333333, 1, 0, 0, 0, dummyWaits);
    drain();
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    int w;
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send(i[0], 9'(130 + i * 20), 23'(i * 32'h12345), i[1], 0, 0, 0, w);
      stalls += w;
    end
    drain();
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL no_bubble: %0d stall cycles, expected 0", stalls); end
    // Random stream with random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(1'($urandom), 9'($urandom_range(0, 511)), 23'($urandom), 1'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 15) == 0), dummyWaits);
        idle();
      end
      begin
        for (int c = 0; c < 120; c++) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom);
        end
        bus.out_ready = 1;
      end
    join
    drain();
  endtask

  task automatic test_flags_clr();
    bus.flags_clr = 1;
    send(0, 9'd450, 23'h0, 0, 0, 0, 0, dummyWaits);
    drain();
    bus.flags_clr = 0;
`ifdef FPM_STICKY_FLAGS_EN
    accum = 4'h0;
    @(negedge clk);
    checks++;
    if (bus.flags !== 4'h0) begin errors++; $display("FAIL flags_clr: got %b expected 0", bus.flags); end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 0;
    send(0, 9'd300, 23'h1, 1, 0, 0, 0, dummyWaits);
    send(1, 9'd999 % 512, 23'h2, 0, 0, 0, 0, dummyWaits);
    idle();
    rst = 1'b0;
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.P !== 32'h0) begin errors++; $display("FAIL midrst_P: got %h expected 0", bus.P); end
    if (bus.flags !== 4'h0) begin errors++; $display("FAIL midrst_flags: got %b expected 0", bus.flags); end
    sbq.delete();
    accum = 4'h0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1;
    send(0, 9'd140, 23'h0F0F0F, 0, 0, 0, 0, dummyWaits);
    idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_latency_early: out_valid=%b expected 0", bus.out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_latency_2: out_valid=%b expected 1", bus.out_valid); end
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow_underflow();
    test_exceptions();
    test_backpressure();
    test_back_to_back();
    test_flags_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
